// File: rtl/row_accum768_pkg.sv
// Shared widths, FSM encoding and result payload for the row reducer.
package row_accum_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ROW_LEN    = 768;
    localparam int unsigned SUM_WIDTH  = 18;
    localparam int unsigned SQ_WIDTH   = 30;
    localparam int unsigned CNT_WIDTH  = $clog2(ROW_LEN);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [SUM_WIDTH-1:0] row_sum;
        logic signed [SQ_WIDTH-1:0]  sq_sum;
    } row_result_t;

endpackage

// File: rtl/row_accum768_if.sv
// Element stream in, row statistics out.
interface row_accum768_if;
    import row_accum_pkg::*;

    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         data_valid_n;
    logic signed [SUM_WIDTH-1:0]  row_sum;
    logic signed [SQ_WIDTH-1:0]   sq_sum;
    logic                         sum_valid_n;
    logic                         row_busy;

    modport master (
        output data_in, data_valid_n,
        input  row_sum, sq_sum, sum_valid_n, row_busy
    );

    modport slave (
        input  data_in, data_valid_n,
        output row_sum, sq_sum, sum_valid_n, row_busy
    );
endinterface

// File: rtl/row_accum768_square_reg.sv
// Registered signed squarer; kept separate so it can map onto a DSP slice.
module square_reg
    import row_accum_pkg::*;
(
    input  logic                         clk_p,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    output logic        [PROD_WIDTH-1:0] p
);

    logic signed [PROD_WIDTH-1:0] prod_c;

    // Square is never negative, so the full product width is a plain magnitude.
    assign prod_c = a * a;

    // Capture the product alongside the sampled element.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= prod_c;
        end
    end

endmodule

// File: rtl/row_accum768.sv
// Streaming row reducer: per-row sum and sum of squares of INT8 activations.
module row_accum768
    import row_accum_pkg::*;
(
    input  logic           clk_p,
    input  logic           rst_n,
    row_accum768_if.slave  bus
);

    // Exact range check: a full row of the most negative value must fit.
    localparam longint unsigned SUM_MAG = 64'(ROW_LEN) << (DATA_WIDTH - 1);
    localparam longint unsigned SQ_MAG  = 64'(ROW_LEN) << (2 * DATA_WIDTH - 2);
    localparam longint unsigned SUM_LIM = 64'(1) << (SUM_WIDTH - 1);
    localparam longint unsigned SQ_LIM  = 64'(1) << (SQ_WIDTH - 1);

    if (ROW_LEN < 2 || SUM_MAG > SUM_LIM || SQ_MAG >= SQ_LIM) begin : g_param_check
        $error("row_accum768: parameter set cannot hold a full row without overflow");
    end

    logic                        sample_c;
    logic                        first_c;
    logic                        last_c;
    logic [CNT_WIDTH-1:0]        elem_cnt;
    logic signed [SUM_WIDTH-1:0] d1;
    logic                        v1;
    logic                        f1;
    logic                        l1;
    logic [PROD_WIDTH-1:0]       p1;
    logic signed [SQ_WIDTH-1:0]  p1_ext;
    logic signed [SUM_WIDTH-1:0] acc_sum;
    logic signed [SQ_WIDTH-1:0]  acc_sq;
    row_result_t                 fin;
    logic                        fin_v;
    state_t                      state;
    state_t                      state_nxt;

    assign sample_c = ~bus.data_valid_n;
    assign first_c  = (elem_cnt == '0);
    assign last_c   = (elem_cnt == CNT_WIDTH'(ROW_LEN - 1));
    assign p1_ext   = SQ_WIDTH'(p1);

    // Position of the next element within its row.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
        end else if (sample_c) begin
            elem_cnt <= last_c ? '0 : elem_cnt + CNT_WIDTH'(1);
        end
    end

    // Stage 1: sign-extended element plus first/last tags.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            v1 <= 1'b0;
            f1 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            v1 <= sample_c;
            if (sample_c) begin
                d1 <= SUM_WIDTH'(bus.data_in);
                f1 <= first_c;
                l1 <= last_c;
            end
        end
    end

    square_reg u_square (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .en    (sample_c),
        .a     (bus.data_in),
        .p     (p1)
    );

    // Stage 2: load on first element so back-to-back rows need no clear.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum <= '0;
            acc_sq  <= '0;
            fin     <= '0;
            fin_v   <= 1'b0;
        end else begin
            fin_v <= v1 & l1;
            if (v1) begin
                acc_sum <= f1 ? d1     : acc_sum + d1;
                acc_sq  <= f1 ? p1_ext : acc_sq + p1_ext;
            end
            if (v1 && l1) begin
                fin.row_sum <= acc_sum + d1;
                fin.sq_sum  <= acc_sq + p1_ext;
            end
        end
    end

    // Final result retimed once more into the output register.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            bus.row_sum     <= '0;
            bus.sq_sum      <= '0;
            bus.sum_valid_n <= 1'b1;
        end else begin
            bus.sum_valid_n <= ~fin_v;
            if (fin_v) begin
                bus.row_sum <= fin.row_sum;
                bus.sq_sum  <= fin.sq_sum;
            end
        end
    end

    // A new first element wins over completion of the previous row.
    always_comb begin
        state_nxt = state;
        if (sample_c && first_c) begin
            state_nxt = ACCUM;
        end else if (v1 && l1) begin
            state_nxt = IDLE;
        end
    end

    // State register; row_busy is registered from next-state terms.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.row_busy <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.row_busy <= (state_nxt == ACCUM) | sample_c;
        end
    end

endmodule

// File: tb/tb_row_accum768.sv
// Scoreboard bench for row_accum768.
module tb_row_accum768;
    import row_accum_pkg::*;

    typedef struct {
        int     sum;
        longint sq;
        int     due;
    } exp_t;

    logic   clk_p;
    logic   rst_n;
    int     cyc;
    int     checks;
    int     errors;
    exp_t   sb[$];
    int     pulse_cyc[$];
    int     m_cnt;
    int     m_sum;
    longint m_sq;
    logic   prev_low;
    logic   busy_watch;
    int     busy_bad;

    row_accum768_if ifc ();

    row_accum768 dut (
        .clk_p (clk_p),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    always @(posedge clk_p) cyc <= cyc + 1;

    // Pops one expected row per pulse and checks values, timing and width.
    always @(negedge clk_p) begin
        if (rst_n) begin
            if (prev_low) begin
                checks++;
                if (ifc.sum_valid_n !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse_width: sum_valid_n=%b at cycle %0d, wanted 1", ifc.sum_valid_n, cyc);
                end
            end
            if (ifc.sum_valid_n === 1'b0 && !prev_low) begin
                pulse_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: pulse at cycle %0d with no row pending", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks += 2;
                    if (ifc.row_sum !== SUM_WIDTH'(e.sum)) begin
                        errors++;
                        $display("FAIL row_sum: got %0d, wanted %0d", ifc.row_sum, e.sum);
                    end
                    if (ifc.sq_sum !== SQ_WIDTH'(e.sq)) begin
                        errors++;
                        $display("FAIL sq_sum: got %0d, wanted %0d", ifc.sq_sum, e.sq);
                    end
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL latency: pulse at cycle %0d, wanted %0d", cyc, e.due);
                    end
                end
            end
            prev_low = (ifc.sum_valid_n === 1'b0);
        end else begin
            prev_low = 1'b0;
        end
    end

    // Drive one element, update the row model, then idle for gap cycles.
    task automatic send(input logic signed [DATA_WIDTH-1:0] v, input int gap);
        exp_t e;
        ifc.data_in      = v;
        ifc.data_valid_n = 1'b0;
        @(posedge clk_p);
        #1;
        if (busy_watch && ifc.row_busy !== 1'b1) busy_bad++;
        if (m_cnt == 0) begin
            m_sum = 0;
            m_sq  = 0;
        end
        m_sum += int'(v);
        m_sq  += longint'(int'(v) * int'(v));
        m_cnt++;
        if (m_cnt == int'(ROW_LEN)) begin
            e.sum = m_sum;
            e.sq  = m_sq;
            e.due = cyc + 2;
            sb.push_back(e);
            m_cnt = 0;
        end
        ifc.data_valid_n = 1'b1;
        repeat (gap) begin
            @(posedge clk_p);
            #1;
        end
    endtask

    // Bounded wait for every pushed row to be observed.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk_p);
            #1;
            n++;
        end
        repeat (2) @(posedge clk_p);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d rows still pending after timeout", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        ifc.data_in      = '0;
        ifc.data_valid_n = 1'b1;
        repeat (3) @(posedge clk_p);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk_p);
        #1;
        checks += 4;
        if (ifc.row_sum !== '0) begin
            errors++;
            $display("FAIL reset_row_sum: got %0d, wanted 0", ifc.row_sum);
        end
        if (ifc.sq_sum !== '0) begin
            errors++;
            $display("FAIL reset_sq_sum: got %0d, wanted 0", ifc.sq_sum);
        end
        if (ifc.sum_valid_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_sum_valid_n: got %b, wanted 1", ifc.sum_valid_n);
        end
        if (ifc.row_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_row_busy: got %b, wanted 0", ifc.row_busy);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < int'(ROW_LEN); i++) send(8'sd1, 0);
        drain();
        checks++;
        if (ifc.row_busy !== 1'b0) begin
            errors++;
            $display("FAIL ones_busy_after: got %b, wanted 0", ifc.row_busy);
        end
    endtask

    task automatic test_min_value();
        for (int i = 0; i < int'(ROW_LEN); i++) send(-8'sd128, 0);
        drain();
        checks++;
        if (ifc.row_sum !== 18'h28000) begin
            errors++;
            $display("FAIL min_row_sum_bits: got %h, wanted 28000", ifc.row_sum);
        end
    endtask

    task automatic test_alternating_gaps();
        for (int i = 0; i < int'(ROW_LEN); i++)
            send((i % 2 == 0) ? 8'sd127 : -8'sd127, int'($urandom_range(0, 3)));
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        n = pulse_cyc.size();
        busy_bad   = 0;
        busy_watch = 1'b1;
        for (int i = 0; i < int'(ROW_LEN); i++) send(8'sd1, 0);
        for (int i = 0; i < int'(ROW_LEN); i++) send(8'sd2, 0);
        busy_watch = 1'b0;
        drain();
        checks += 2;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL b2b_busy: row_busy low on %0d sampled cycles, wanted 0", busy_bad);
        end
        if (pulse_cyc.size() != n + 2 || pulse_cyc[n + 1] - pulse_cyc[n] != int'(ROW_LEN)) begin
            errors++;
            $display("FAIL b2b_spacing: %0d pulses seen, wanted 2 spaced %0d cycles", pulse_cyc.size() - n, ROW_LEN);
        end
    endtask

    task automatic test_reset_mid_row();
        int q;
        for (int i = 0; i < 300; i++) send(8'sd5, 0);
        rst_n = 1'b0;
        m_cnt = 0;
        #3;
        rst_n = 1'b1;
        #1;
        checks += 2;
        if (ifc.row_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, wanted 0", ifc.row_busy);
        end
        if (ifc.row_sum !== '0) begin
            errors++;
            $display("FAIL abort_row_sum: got %0d, wanted 0", ifc.row_sum);
        end
        repeat (5) @(posedge clk_p);
        #1;
        for (int i = 0; i < int'(ROW_LEN); i++) send(8'sd3, 0);
        drain();
        q = int'(ifc.row_sum) / int'(ROW_LEN);
        checks++;
        if (q != 3) begin
            errors++;
            $display("FAIL abort_mean: row_sum/%0d got %0d, wanted 3", ROW_LEN, q);
        end
    endtask

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        m_cnt      = 0;
        m_sum      = 0;
        m_sq       = 0;
        prev_low   = 1'b0;
        busy_watch = 1'b0;
        busy_bad   = 0;
        test_reset();
        test_ones();
        test_min_value();
        test_alternating_gaps();
        test_back_to_back();
        test_reset_mid_row();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
